// File: rtl/mcu_link_pkg.sv
// Shared definitions for both ends of the FPGA<->MCU front-panel UART link:
// opcode nibbles, request/reply codes, frame lengths and state encodings.
package mcu_link_pkg;

  localparam logic [3:0] OP_STAGE   = 4'h2;
  localparam logic [3:0] OP_VER     = 4'h3;
  localparam logic [3:0] OP_IP      = 4'h4;
  localparam logic [3:0] OP_STATUS  = 4'h5;
  localparam logic [3:0] OP_POWERON = 4'h6;

  localparam logic [7:0] REQ_STATUS  = 8'h50;
  localparam logic [7:0] REQ_POWERON = 8'h60;
  localparam logic [7:0] SET_PWR_ON  = 8'h61;
  localparam logic [7:0] SET_PWR_OFF = 8'h62;

  localparam logic [1:0] PWR_ON_CODE  = 2'b01;
  localparam logic [1:0] PWR_OFF_CODE = 2'b10;

  localparam int IP_FRAME_LEN  = 16;
  localparam int VER_FRAME_LEN = 8;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_IP   = 2'd1,
    R_VER  = 2'd2
  } rx_state_t;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_HOLD = 1'b1
  } tx_state_t;

endpackage

// File: rtl/mcu_link_tx_arb.sv
// Reply arbiter: holds status/poweron pending flags and offers one byte at a
// time to the UART TX with a valid/ready handshake.
module mcu_link_tx_arb
  import mcu_link_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       status_set,
  input  logic       poweron_set,
  input  logic [1:0] slot,
  input  logic       power_amplifier,
  input  logic       audio_amplifier,
  input  logic       poweron,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_byte
);

  tx_state_t state;
  logic      status_pending;
  logic      poweron_pending;

  // Set requests are applied after the clear, so a request arriving on the
  // load cycle survives and produces a second byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= T_IDLE;
      status_pending  <= 1'b0;
      poweron_pending <= 1'b0;
      tx_valid        <= 1'b0;
      tx_byte         <= 8'h00;
    end else begin
      case (state)
        T_IDLE: begin
          if (status_pending) begin
            tx_byte        <= {OP_STATUS, slot, power_amplifier, audio_amplifier};
            tx_valid       <= 1'b1;
            status_pending <= 1'b0;
            state          <= T_HOLD;
          end else if (poweron_pending) begin
            tx_byte         <= {OP_POWERON, 2'b00, poweron ? PWR_ON_CODE : PWR_OFF_CODE};
            tx_valid        <= 1'b1;
            poweron_pending <= 1'b0;
            state           <= T_HOLD;
          end
        end
        T_HOLD: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= T_IDLE;
          end
        end
        default: state <= T_IDLE;
      endcase
      if (status_set)  status_pending  <= 1'b1;
      if (poweron_set) poweron_pending <= 1'b1;
    end
  end

endmodule

// File: rtl/mcu_link_responder.sv
// MCU-side responder of the front-panel link: decodes the FPGA byte stream,
// tracks local key state and answers status/poweron requests.
module mcu_link_responder
  import mcu_link_pkg::*;
#(
  parameter int         TIMEOUT_CLKS = 1228800,
  parameter logic [1:0] RESET_SLOT   = 2'd0
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  input  logic        tx_ready,
  input  logic        key_slot_next,
  input  logic        key_pa_toggle,
  input  logic        key_aa_toggle,
  input  logic        key_poweron_toggle,
  output logic [31:0] ip,
  output logic        ip_update,
  output logic [63:0] fw_version,
  output logic [3:0]  fw_type,
  output logic        version_update,
  output logic [3:0]  stage,
  output logic        stage_update,
  output logic [1:0]  slot,
  output logic        power_amplifier,
  output logic        audio_amplifier,
  output logic        poweron,
  output logic [7:0]  frame_err_cnt
);

  localparam int IDLE_W = $clog2(TIMEOUT_CLKS + 1);

  rx_state_t         rx_state;
  logic [4:0]        cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [31:0]       shadow_ip;
  logic [63:0]       shadow_ver;
  logic [3:0]        shadow_type;

  logic [3:0] op_hi;
  logic [3:0] op_lo;
  logic       opcode_rx;
  logic       timeout_hit;
  logic       err_inc;
  logic [1:0] slot_n;
  logic       pa_n;
  logic       aa_n;
  logic       poweron_n;
  logic       status_set;
  logic       poweron_set;

  assign op_hi       = rx_byte[7:4];
  assign op_lo       = rx_byte[3:0];
  assign opcode_rx   = rx_valid && (rx_state == R_IDLE);
  assign timeout_hit = (rx_state != R_IDLE) && !rx_valid &&
                       (idle_cnt == IDLE_W'(TIMEOUT_CLKS - 1));

  // The rx write lands first; key toggles then modify that value.
  always_comb begin
    slot_n      = slot;
    pa_n        = power_amplifier;
    aa_n        = audio_amplifier;
    poweron_n   = poweron;
    status_set  = key_slot_next | key_pa_toggle | key_aa_toggle;
    poweron_set = key_poweron_toggle;
    err_inc     = timeout_hit;
    if (opcode_rx) begin
      case (op_hi)
        OP_STAGE, OP_VER, OP_IP: ;
        OP_STATUS: begin
          if (op_lo == 4'h0) begin
            status_set = 1'b1;
          end else begin
            slot_n = op_lo[3:2];
            pa_n   = op_lo[1];
            aa_n   = op_lo[0];
          end
        end
        OP_POWERON: begin
          if (rx_byte == REQ_POWERON)      poweron_set = 1'b1;
          else if (rx_byte == SET_PWR_ON)  poweron_n   = 1'b1;
          else if (rx_byte == SET_PWR_OFF) poweron_n   = 1'b0;
          else                             err_inc     = 1'b1;
        end
        default: err_inc = 1'b1;
      endcase
    end
    if (key_slot_next)      slot_n    = slot_n + 2'd1;
    if (key_pa_toggle)      pa_n      = ~pa_n;
    if (key_aa_toggle)      aa_n      = ~aa_n;
    if (key_poweron_toggle) poweron_n = ~poweron_n;
  end

  // Multi-byte frames build up in shadow registers and only reach the outputs
  // on the final byte, so a stalled or reset frame never leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state        <= R_IDLE;
      cnt             <= 5'd0;
      idle_cnt        <= '0;
      shadow_ip       <= 32'h0;
      shadow_ver      <= 64'h0;
      shadow_type     <= 4'h0;
      ip              <= 32'h0;
      ip_update       <= 1'b0;
      fw_version      <= 64'h0;
      fw_type         <= 4'h0;
      version_update  <= 1'b0;
      stage           <= 4'h0;
      stage_update    <= 1'b0;
      slot            <= RESET_SLOT;
      power_amplifier <= 1'b0;
      audio_amplifier <= 1'b0;
      poweron         <= 1'b0;
      frame_err_cnt   <= 8'h00;
    end else begin
      ip_update       <= 1'b0;
      version_update  <= 1'b0;
      stage_update    <= 1'b0;
      slot            <= slot_n;
      power_amplifier <= pa_n;
      audio_amplifier <= aa_n;
      poweron         <= poweron_n;
      if (err_inc && frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;

      case (rx_state)
        R_IDLE: begin
          idle_cnt <= '0;
          if (rx_valid) begin
            case (op_hi)
              OP_IP: begin
                rx_state  <= R_IP;
                cnt       <= 5'd0;
                shadow_ip <= 32'h0;
              end
              OP_VER: begin
                rx_state    <= R_VER;
                cnt         <= 5'd0;
                shadow_type <= op_lo;
                shadow_ver  <= 64'h0;
              end
              OP_STAGE: begin
                stage        <= op_lo;
                stage_update <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        R_IP: begin
          if (rx_valid) begin
            idle_cnt <= '0;
            if (cnt < 5'd4) shadow_ip <= {shadow_ip[23:0], rx_byte};
            if (cnt == 5'(IP_FRAME_LEN - 1)) begin
              ip        <= shadow_ip;
              ip_update <= 1'b1;
              rx_state  <= R_IDLE;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end else if (timeout_hit) begin
            shadow_ip <= 32'h0;
            idle_cnt  <= '0;
            rx_state  <= R_IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        R_VER: begin
          if (rx_valid) begin
            idle_cnt <= '0;
            if (cnt == 5'(VER_FRAME_LEN - 1)) begin
              fw_version     <= {shadow_ver[55:0], rx_byte};
              fw_type        <= shadow_type;
              version_update <= 1'b1;
              rx_state       <= R_IDLE;
            end else begin
              shadow_ver <= {shadow_ver[55:0], rx_byte};
              cnt        <= cnt + 5'd1;
            end
          end else if (timeout_hit) begin
            shadow_ver  <= 64'h0;
            shadow_type <= 4'h0;
            idle_cnt    <= '0;
            rx_state    <= R_IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  mcu_link_tx_arb u_tx_arb (
    .clk             (clk),
    .rst_n           (rst_n),
    .status_set      (status_set),
    .poweron_set     (poweron_set),
    .slot            (slot),
    .power_amplifier (power_amplifier),
    .audio_amplifier (audio_amplifier),
    .poweron         (poweron),
    .tx_ready        (tx_ready),
    .tx_valid        (tx_valid),
    .tx_byte         (tx_byte)
  );

endmodule

// File: tb/tb_mcu_link_responder.sv
// Directed bench for mcu_link_responder: frames, requests, keys, timeout,
// reset recovery and error-counter saturation against hand-computed values.
module tb_mcu_link_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready;
  logic        key_slot_next;
  logic        key_pa_toggle;
  logic        key_aa_toggle;
  logic        key_poweron_toggle;
  logic [31:0] ip;
  logic        ip_update;
  logic [63:0] fw_version;
  logic [3:0]  fw_type;
  logic        version_update;
  logic [3:0]  stage;
  logic        stage_update;
  logic [1:0]  slot;
  logic        power_amplifier;
  logic        audio_amplifier;
  logic        poweron;
  logic [7:0]  frame_err_cnt;

  int total = 0;
  int bad = 0;

  int ip_upd_n = 0;
  int ver_upd_n = 0;
  int stage_upd_n = 0;
  int tx_count = 0;
  logic [7:0] tx_log [0:63];

  always #5 clk = ~clk;

  mcu_link_responder #(.TIMEOUT_CLKS(1000), .RESET_SLOT(2'd0)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rx_valid           (rx_valid),
    .rx_byte            (rx_byte),
    .tx_valid           (tx_valid),
    .tx_byte            (tx_byte),
    .tx_ready           (tx_ready),
    .key_slot_next      (key_slot_next),
    .key_pa_toggle      (key_pa_toggle),
    .key_aa_toggle      (key_aa_toggle),
    .key_poweron_toggle (key_poweron_toggle),
    .ip                 (ip),
    .ip_update          (ip_update),
    .fw_version         (fw_version),
    .fw_type            (fw_type),
    .version_update     (version_update),
    .stage              (stage),
    .stage_update       (stage_update),
    .slot               (slot),
    .power_amplifier    (power_amplifier),
    .audio_amplifier    (audio_amplifier),
    .poweron            (poweron),
    .frame_err_cnt      (frame_err_cnt)
  );

  // Pulse and handshake logs, read by the stimulus thread as deltas.
  always @(posedge clk) begin
    if (ip_update)      ip_upd_n    <= ip_upd_n + 1;
    if (version_update) ver_upd_n   <= ver_upd_n + 1;
    if (stage_update)   stage_upd_n <= stage_upd_n + 1;
    if (tx_valid && tx_ready && tx_count < 64) begin
      tx_log[tx_count] <= tx_byte;
      tx_count         <= tx_count + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; keys = {slot_next, pa, aa, poweron}.
  task automatic applyStimulus(input logic [7:0] b, input logic do_rx, input logic [3:0] keys);
    @(negedge clk);
    rx_valid = do_rx;
    rx_byte  = b;
    {key_slot_next, key_pa_toggle, key_aa_toggle, key_poweron_toggle} = keys;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    {key_slot_next, key_pa_toggle, key_aa_toggle, key_poweron_toggle} = 4'h0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(b, 1'b1, 4'h0);
  endtask

  task automatic waitClks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base;
    int n0;
    int n1;
    logic stable;
    logic [7:0] ip_a [0:3];
    logic [7:0] ip_b [0:3];

    ip_a[0] = 8'hC0; ip_a[1] = 8'hA8; ip_a[2] = 8'h01; ip_a[3] = 8'h0A;
    ip_b[0] = 8'h0A; ip_b[1] = 8'h00; ip_b[2] = 8'h00; ip_b[3] = 8'h01;

    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_byte = 8'h00;
    tx_ready = 1'b1;
    {key_slot_next, key_pa_toggle, key_aa_toggle, key_poweron_toggle} = 4'h0;
    waitClks(3);
    checkOutput("reset_ip", 64'(ip), 64'h0);
    checkOutput("reset_slot", 64'(slot), 64'h0);
    checkOutput("reset_tx_valid", 64'(tx_valid), 64'h0);
    checkOutput("reset_err", 64'(frame_err_cnt), 64'h0);
    checkOutput("reset_fields", 64'({stage, fw_type, power_amplifier, audio_amplifier, poweron}), 64'h0);
    rst_n = 1'b1;
    waitClks(2);

    // IP frame: 4 address bytes then 12 padding bytes, no reply expected.
    base = tx_count;
    n0 = ip_upd_n;
    sendByte(8'h40);
    for (int i = 0; i < 4; i++) sendByte(ip_a[i]);
    for (int i = 0; i < 11; i++) sendByte(8'h00);
    checkOutput("ip_not_early", 64'(ip), 64'h0);
    sendByte(8'h00);
    waitClks(2);
    checkOutput("ip_value", 64'(ip), 64'hC0A8010A);
    checkOutput("ip_update_once", 64'(ip_upd_n - n0), 64'd1);
    checkOutput("ip_no_tx", 64'(tx_count - base), 64'd0);

    // Version frame and stage byte.
    n0 = ver_upd_n;
    sendByte(8'h31);
    for (int i = 1; i <= 8; i++) sendByte(8'(i));
    waitClks(2);
    checkOutput("fw_type", 64'(fw_type), 64'h1);
    checkOutput("fw_version", fw_version, 64'h0102030405060708);
    checkOutput("version_update_once", 64'(ver_upd_n - n0), 64'd1);
    n1 = stage_upd_n;
    sendByte(8'h24);
    waitClks(2);
    checkOutput("stage4", 64'(stage), 64'h4);
    checkOutput("stage_update_once", 64'(stage_upd_n - n1), 64'd1);

    // Status set then request, with TX back-pressured for 100 clocks.
    tx_ready = 1'b0;
    base = tx_count;
    sendByte(8'h5D);
    checkOutput("status_set_fields", 64'({slot, power_amplifier, audio_amplifier}), 64'hD);
    checkOutput("status_set_no_reply", 64'(tx_valid), 64'h0);
    sendByte(8'h50);
    waitClks(2);
    checkOutput("status_offer_valid", 64'(tx_valid), 64'h1);
    checkOutput("status_offer_byte", 64'(tx_byte), 64'h5D);
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!(tx_valid === 1'b1 && tx_byte === 8'h5D)) stable = 1'b0;
    end
    checkOutput("status_hold_stable", 64'(stable), 64'h1);
    tx_ready = 1'b1;
    waitClks(4);
    checkOutput("status_one_handshake", 64'(tx_count - base), 64'd1);
    checkOutput("status_logged_byte", 64'(tx_log[base]), 64'h5D);
    checkOutput("status_valid_dropped", 64'(tx_valid), 64'h0);

    // Poweron set, request, and local toggle.
    base = tx_count;
    sendByte(8'h61);
    sendByte(8'h60);
    waitClks(4);
    checkOutput("poweron_set", 64'(poweron), 64'h1);
    checkOutput("poweron_reply_cnt", 64'(tx_count - base), 64'd1);
    checkOutput("poweron_reply_byte", 64'(tx_log[base]), 64'h61);
    base = tx_count;
    applyStimulus(8'h00, 1'b0, 4'b0001);
    waitClks(4);
    checkOutput("poweron_key_value", 64'(poweron), 64'h0);
    checkOutput("poweron_key_cnt", 64'(tx_count - base), 64'd1);
    checkOutput("poweron_key_byte", 64'(tx_log[base]), 64'h62);

    // Poweron request and slot key together: status first (slot wraps 3->0).
    base = tx_count;
    applyStimulus(8'h60, 1'b1, 4'b1000);
    waitClks(8);
    checkOutput("both_slot_wrap", 64'(slot), 64'h0);
    checkOutput("both_cnt", 64'(tx_count - base), 64'd2);
    checkOutput("both_first", 64'(tx_log[base]), 64'h51);
    checkOutput("both_second", 64'(tx_log[base + 1]), 64'h62);

    // Partial IP frame, then silence past the timeout.
    sendByte(8'h40);
    sendByte(8'h11);
    sendByte(8'h22);
    sendByte(8'h33);
    waitClks(500);
    checkOutput("timeout_not_yet", 64'(frame_err_cnt), 64'h0);
    waitClks(600);
    checkOutput("timeout_err", 64'(frame_err_cnt), 64'h1);
    checkOutput("timeout_ip_kept", 64'(ip), 64'hC0A8010A);
    sendByte(8'h23);
    waitClks(1);
    checkOutput("timeout_then_stage", 64'(stage), 64'h3);

    // Offer a byte that never completes, then reset in the middle of an IP frame.
    tx_ready = 1'b0;
    applyStimulus(8'h00, 1'b0, 4'b0100);
    waitClks(3);
    checkOutput("pre_reset_valid", 64'(tx_valid), 64'h1);
    checkOutput("pre_reset_byte", 64'(tx_byte), 64'h53);
    sendByte(8'h40);
    for (int i = 0; i < 8; i++) sendByte(8'hEE);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_drops_valid", 64'(tx_valid), 64'h0);
    waitClks(2);
    checkOutput("reset_mid_ip", 64'(ip), 64'h0);
    checkOutput("reset_mid_fields", 64'({stage, slot, power_amplifier, poweron, frame_err_cnt}), 64'h0);
    checkOutput("reset_mid_ver", fw_version, 64'h0);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    waitClks(2);

    n0 = ip_upd_n;
    sendByte(8'h40);
    for (int i = 0; i < 4; i++) sendByte(ip_b[i]);
    for (int i = 0; i < 12; i++) sendByte(8'h00);
    waitClks(2);
    checkOutput("post_reset_ip", 64'(ip), 64'h0A000001);
    checkOutput("post_reset_ip_pulse", 64'(ip_upd_n - n0), 64'd1);

    // Unknown opcodes saturate the error counter.
    sendByte(8'h63);
    checkOutput("err_0x63", 64'(frame_err_cnt), 64'h1);
    for (int i = 0; i < 300; i++) sendByte(8'h7F);
    checkOutput("err_saturate", 64'(frame_err_cnt), 64'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mcu_link_responder.md
Name: mcu_link_responder

Overview:
MCU-side end of the FPGA↔MCU front-panel UART link, implemented in fabric for the companion/front-panel FPGA and reused as the bench responder for the bootloader link.
It parses the byte stream the FPGA sends (IP, version, stage, status, requests) and exposes the decoded values.
It answers 0x50/0x60 requests and emits unsolicited status/poweron bytes on local key events.
It sits between a byte-level UART RX/TX pair and the display/key logic.

Parameters:
TIMEOUT_CLKS, 1228800, idle clocks (10 ms @122.88 MHz) after which a partial multi-byte frame is aborted
RESET_SLOT, 2'd0, slot value after reset

Ports:
clk  in  1  system clock (122.88 MHz)
rst_n  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle strobe, rx_byte valid
rx_byte  in  8  byte from UART RX
tx_valid  out  1  byte offered to UART TX
tx_byte  out  8  byte to transmit
tx_ready  in  1  UART TX accepts tx_byte when tx_valid&tx_ready
key_slot_next  in  1  pulse: slot <= slot+1 (wraps 3→0)
key_pa_toggle  in  1  pulse: toggle power_amplifier
key_aa_toggle  in  1  pulse: toggle audio_amplifier
key_poweron_toggle  in  1  pulse: toggle poweron
ip  out  32  last received IPv4 address, MSB first on the wire
ip_update  out  1  one-cycle pulse when ip committed
fw_version  out  64  last received version bytes, first byte in [63:56]
fw_type  out  4  low nibble of 0x3t opcode
version_update  out  1  one-cycle pulse on version commit
stage  out  4  last stage nibble
stage_update  out  1  one-cycle pulse on stage byte
slot  out  2  current slot
power_amplifier  out  1  current PA state
audio_amplifier  out  1  current audio amp state
poweron  out  1  auto power-on option
frame_err_cnt  out  8  saturating count of aborted frames and unknown opcodes

Behaviour:
- Reset values: all outputs 0 except slot=RESET_SLOT. Receiver in R_IDLE, TX pending flags cleared, shadow registers discarded.
- Receiver FSM states: R_IDLE, R_IP, R_VER. Byte counter is 5 bits.
- R_IDLE decodes the opcode on rx_valid:
  - 0x40 → R_IP, cnt=0.
  - 0x3t → latch t into shadow type, R_VER, cnt=0.
  - 0x2s → stage<=s, stage_update pulse next cycle.
  - 0x50 → request: set status_pending.
  - 0x5x, x≠0 → slot/pa/aa <= x[3:2]/x[1]/x[0]. No reply.
  - 0x60 → request: set poweron_pending.
  - 0x61 → poweron<=1; 0x62 → poweron<=0; 0x63 → ignored, error++.
  - Opcodes 0x0_, 0x1_, 0x7_–0xF_ → ignored, error++.
- R_IP: takes 16 payload bytes. Bytes 0–3 shift into the shadow IP; bytes 4–15 are padding, value ignored. After the 16th byte, commit ip and pulse ip_update, then → R_IDLE.
- R_VER: takes 8 bytes into the shadow version. After the 8th byte, commit fw_version/fw_type and pulse version_update, then → R_IDLE.
- Outputs never show a partially received frame.
- Timeout:
  - Idle counter counts clocks since the last rx_valid while in R_IP/R_VER.
  - When it reaches TIMEOUT_CLKS: discard the shadow, error++, → R_IDLE.
  - An rx_valid in the same cycle wins and clears the counter.
- Local keys:
  - A key pulse updates the field on the next edge and sets the matching pending flag (status keys → status_pending, key_poweron_toggle → poweron_pending).
  - Keys and rx update of the same field in the same cycle: rx value is written first, then the key modification is applied to it.
- TX arbiter, states T_IDLE and T_HOLD:
  - In T_IDLE, if status_pending: tx_byte={4'h5,slot,pa,aa}, clear status_pending.
  - Else if poweron_pending: tx_byte={4'h6,2'b0,poweron?2'b01:2'b10}, clear poweron_pending.
  - Either case sets tx_valid=1 and → T_HOLD.
  - In T_HOLD, tx_byte and tx_valid are held stable until tx_ready; then tx_valid=0 → T_IDLE. One idle cycle minimum between bytes.
  - The byte is sampled from current field values at load time. Multiple requests/keys before load coalesce into one byte.
  - A pending set in the same cycle its flag is cleared stays set and yields a second byte.
- Reset mid-TX drops tx_valid immediately. Reset mid-frame discards the shadow.
- frame_err_cnt saturates at 255.

Decomposition:
- Package mcu_link_pkg holds:
  - opcode nibbles (OP_STAGE=2, OP_VER=3, OP_IP=4, OP_STATUS=5, OP_POWERON=6)
  - request bytes 0x50/0x60, poweron codes 01/10
  - IP_FRAME_LEN=16, VER_FRAME_LEN=8
  - receiver/TX state enums
- Shared by this block and the FPGA-side mcu link.
- One sub-module, mcu_link_tx_arb: pending flags, priority, valid/ready hold.

Test Plan:
- 0x40,C0,A8,01,0A,+12×0x00 → ip=0xC0A8010A, one ip_update pulse, no tx.
- 0x31,01..08 → fw_type=1, fw_version=0x0102030405060708, version_update once; 0x24 → stage=4 with pulse.
- 0x5D then 0x50 → slot=3, pa=0, aa=1; tx_byte 0x5D offered. With tx_ready held low 100 clks, byte stays stable; then 1 handshake.
- 0x61 then 0x60 → poweron=1, tx 0x61; key_poweron_toggle → tx 0x62. 0x60 and key_slot_next in the same cycle → status sent first, then poweron.
- 0x40 plus 3 bytes then silence → after TIMEOUT_CLKS (param 1000 in bench): frame_err_cnt=1, ip unchanged; the next 0x23 decodes as stage=3.
- rst_n low after 9 bytes of an IP frame → outputs at reset values. A full frame afterwards decodes correctly. 300 bytes of 0x7F → frame_err_cnt=255.
